cluster_req_sync: RTL and testbench

- Successor to the fixed request fork plus unused completion stub in the multi-cluster Ara top.
- Broadcasts each CVA6 accelerator request to a runtime-selectable subset of NrClusters Ara instances. A request is accepted upstream only once every enabled cluster has taken it.
- Merges per-cluster, per-unit completion pulses into global completion pulses.
- Bounds in-flight requests with an outstanding counter, retired by a synchronised retire event.

---
 rtl/cluster_req_sync_pkg.sv | 20 ++
 rtl/cluster_req_sync_if.sv | 38 +++
 rtl/cluster_compl_merge.sv | 35 +++
 rtl/cluster_req_sync.sv | 137 +++++++++++++
 tb/tb_cluster_req_sync.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cluster_req_sync_pkg.sv
// Shared defaults, mask types and sizing helpers for the cluster request
// broadcaster and completion merger.
package cluster_req_sync_pkg;

    localparam int unsigned DefaultNrClusters     = 4;
    localparam int unsigned NrVFUs                = 8;
    localparam int unsigned DefaultNrUnits        = NrVFUs;
    localparam int unsigned DefaultReqWidth       = 128;
    localparam int unsigned DefaultMaxOutstanding = 4;
    localparam int unsigned DefaultTimeoutCycles  = 1024;

    typedef logic [DefaultNrClusters-1:0] cluster_mask_t;
    typedef logic [NrVFUs-1:0]            vfu_mask_t;

    // Width of a counter that must represent 0..max_count inclusive.
    function automatic int unsigned count_width(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/cluster_req_sync_if.sv
// Request fork / completion merge bundle between the CVA6 side (master)
// and the cluster synchroniser (slave).
interface cluster_req_sync_if
    import cluster_req_sync_pkg::*;
#(
    parameter int unsigned NrClusters     = DefaultNrClusters,
    parameter int unsigned ReqWidth       = DefaultReqWidth,
    parameter int unsigned NrUnits        = DefaultNrUnits,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding
);

    logic                                      req_valid_i;
    logic                                      req_ready_o;
    logic [ReqWidth-1:0]                       req_data_i;
    logic [NrClusters-1:0]                     cluster_en_i;
    logic [NrClusters-1:0]                     clu_req_valid_o;
    logic [NrClusters-1:0]                     clu_req_ready_i;
    logic [ReqWidth-1:0]                       clu_req_data_o;
    logic [NrClusters*NrUnits-1:0]             compl_i;
    logic [NrClusters-1:0]                     retire_i;
    logic [NrUnits-1:0]                        compl_sync_o;
    logic [count_width(MaxOutstanding)-1:0]    outstanding_o;
    logic                                      busy_o;
    logic                                      timeout_o;

    modport slave (
        input  req_valid_i, req_data_i, cluster_en_i, clu_req_ready_i, compl_i, retire_i,
        output req_ready_o, clu_req_valid_o, clu_req_data_o, compl_sync_o,
               outstanding_o, busy_o, timeout_o
    );

    modport master (
        output req_valid_i, req_data_i, cluster_en_i, clu_req_ready_i, compl_i, retire_i,
        input  req_ready_o, clu_req_valid_o, clu_req_data_o, compl_sync_o,
               outstanding_o, busy_o, timeout_o
    );

endinterface

// File: rtl/cluster_compl_merge.sv
// One completion lane: per-cluster pending bits and the all-clusters-seen
// fire condition. Pulses from disabled clusters are ignored.
module cluster_compl_merge #(
    parameter int unsigned NrClusters = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NrClusters-1:0] en,
    input  logic [NrClusters-1:0] pulse,
    output logic                  fire
);

    logic [NrClusters-1:0] pending_q;
    logic [NrClusters-1:0] pending_d;
    logic [NrClusters-1:0] hit;

    // An empty mask would make every lane fire forever, so it never fires.
    always_comb begin
        hit       = pending_q | pulse | ~en;
        fire      = (&hit) & (|en);
        pending_d = pending_q | (pulse & en);
        if (fire) begin
            pending_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/cluster_req_sync.sv
// Broadcasts accelerator requests to the enabled clusters and merges their
// completions. Optional watchdog: define CLUSTER_REQ_SYNC_TIMEOUT_EN.
module cluster_req_sync
    import cluster_req_sync_pkg::*;
#(
    parameter int unsigned NrClusters     = DefaultNrClusters,
    parameter int unsigned ReqWidth       = DefaultReqWidth,
    parameter int unsigned NrUnits        = DefaultNrUnits,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
    parameter int unsigned TimeoutCycles  = DefaultTimeoutCycles
) (
    input logic               clk_i,
    input logic               rst_ni,
    cluster_req_sync_if.slave bus
);

    localparam int unsigned           CntWidth = count_width(MaxOutstanding);
    localparam logic [CntWidth-1:0]   MaxCount = CntWidth'(MaxOutstanding);

    if (NrClusters < 1 || NrUnits < 1 || ReqWidth < 1 ||
        MaxOutstanding < 1 || TimeoutCycles < 1) begin : g_bad_params
        $error("cluster_req_sync: parameter out of range");
    end

    logic [NrClusters-1:0] en_q;
    logic [NrClusters-1:0] sent_q;
    logic [NrClusters-1:0] sent_d;
    logic [NrClusters-1:0] done;
    logic [NrClusters-1:0] fork_valid;
    logic [NrClusters-1:0] fork_hs;
    logic [CntWidth-1:0]   outstanding_q;
    logic [CntWidth-1:0]   outstanding_d;
    logic                  credit_ok;
    logic                  accept;
    logic                  busy;
    logic                  retire_fire;
    logic [NrUnits:0]      fire;
    logic [NrUnits-1:0]    compl_sync_q;

    // Lanes 0..NrUnits-1 merge unit completions; the last lane merges retires.
    for (genvar u = 0; u <= NrUnits; u++) begin : g_lane
        logic [NrClusters-1:0] lane_pulse;
        for (genvar c = 0; c < NrClusters; c++) begin : g_gather
            if (u < NrUnits) begin : g_unit
                assign lane_pulse[c] = bus.compl_i[c*NrUnits+u];
            end else begin : g_retire
                assign lane_pulse[c] = bus.retire_i[c];
            end
        end
        cluster_compl_merge #(
            .NrClusters(NrClusters)
        ) u_merge (
            .clk  (clk_i),
            .rst_n(rst_ni),
            .en   (en_q),
            .pulse(lane_pulse),
            .fire (fire[u])
        );
    end

    always_comb begin
        credit_ok   = (outstanding_q < MaxCount) && (en_q != '0);
        fork_valid  = {NrClusters{bus.req_valid_i & credit_ok}} & en_q & ~sent_q;
        fork_hs     = fork_valid & bus.clu_req_ready_i;
        done        = sent_q | bus.clu_req_ready_i | ~en_q;
        accept      = bus.req_valid_i & credit_ok & (&done);
        sent_d      = sent_q | fork_hs;
        if (accept) begin
            sent_d = '0;
        end
        busy        = (outstanding_q != '0) || (sent_q != '0);
        retire_fire = fire[NrUnits];
        outstanding_d = outstanding_q;
        case ({accept, retire_fire})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // The mask also holds on a lone cluster handshake so sent_q never
    // refers to a cluster that was enabled under a different mask.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            en_q          <= '1;
            sent_q        <= '0;
            outstanding_q <= '0;
            compl_sync_q  <= '0;
        end else begin
            if (!busy && !accept && (fork_hs == '0)) begin
                en_q <= bus.cluster_en_i;
            end
            sent_q        <= sent_d;
            outstanding_q <= outstanding_d;
            compl_sync_q  <= fire[NrUnits-1:0];
        end
    end

    retire_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(retire_fire && !accept && (outstanding_q == '0)));

`ifdef CLUSTER_REQ_SYNC_TIMEOUT_EN
    localparam int unsigned TimerWidth = count_width(TimeoutCycles);

    logic [TimerWidth-1:0] timer_q;
    logic                  timeout_q;

    // Counts cycles a partially forked request waits; flag is sticky.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else if ((sent_q != '0) && !accept) begin
            if (timer_q != TimerWidth'(TimeoutCycles)) begin
                timer_q <= timer_q + 1'b1;
            end
            if (timer_q == TimerWidth'(TimeoutCycles - 1)) begin
                timeout_q <= 1'b1;
            end
        end else begin
            timer_q <= '0;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.req_ready_o     = accept;
    assign bus.clu_req_valid_o = fork_valid;
    assign bus.clu_req_data_o  = bus.req_data_i;
    assign bus.compl_sync_o    = compl_sync_q;
    assign bus.outstanding_o   = outstanding_q;
    assign bus.busy_o          = busy;

endmodule

// File: tb/tb_cluster_req_sync.sv
// Scoreboard bench for cluster_req_sync: directed stimulus pushes expected
// handshakes/pulses, a negedge monitor pops and compares them.
module tb_cluster_req_sync;
    import cluster_req_sync_pkg::*;

    localparam int unsigned NC = 4;
    localparam int unsigned NU = 8;
    localparam int unsigned RW = 128;
    localparam int unsigned MO = 2;
    localparam int unsigned TO = 16;

`ifdef CLUSTER_REQ_SYNC_TIMEOUT_EN
    localparam logic TimeoutExp = 1'b1;
`else
    localparam logic TimeoutExp = 1'b0;
`endif

    localparam logic [RW-1:0] D1 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    localparam logic [RW-1:0] D2 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    localparam logic [RW-1:0] D3 = 128'h0000_0000_0000_0000_0000_0000_0000_0003;
    localparam logic [RW-1:0] D4 = 128'h4444_0000_0000_0000_0000_0000_0000_0004;
    localparam logic [RW-1:0] D5 = 128'h5555_5555_0000_0000_0000_0000_0000_0005;
    localparam logic [RW-1:0] D6 = 128'hcafe_f00d_6666_6666_6666_6666_6666_6666;
    localparam logic [RW-1:0] D7 = 128'h7777_7777_7777_7777_7777_7777_abcd_ef01;

    typedef struct packed { int cyc; cluster_mask_t mask; } hs_t;
    typedef struct packed { int cyc; logic [RW-1:0] data; int outst; } acc_t;
    typedef struct packed { int cyc; vfu_mask_t lanes; } sync_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_en = 1'b0;
    cluster_mask_t en_cur = 4'hF;

    hs_t   hs_q[$];
    acc_t  acc_q[$];
    sync_t sync_q[$];

    cluster_req_sync_if #(
        .NrClusters(NC), .ReqWidth(RW), .NrUnits(NU), .MaxOutstanding(MO)
    ) bus ();

    cluster_req_sync #(
        .NrClusters(NC), .ReqWidth(RW), .NrUnits(NU),
        .MaxOutstanding(MO), .TimeoutCycles(TO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] act);
        n_checks++;
        n_errors++;
        $display("[TB] FAIL %s: got %0h, expected no event (cycle %0d)", name, act, cyc);
    endtask

    task automatic applyStimulus(input logic vld, input logic [RW-1:0] data,
                                 input logic [NC-1:0] rdy, input logic [NC*NU-1:0] compl,
                                 input logic [NC-1:0] retire);
        bus.req_valid_i     = vld;
        bus.req_data_i      = data;
        bus.clu_req_ready_i = rdy;
        bus.compl_i         = compl;
        bus.retire_i        = retire;
        bus.cluster_en_i    = en_cur;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, '0, '0);
        nextCycle();
    endtask

    task automatic retireCycle(input logic [NC-1:0] mask);
        applyStimulus(1'b0, '0, '0, '0, mask);
        nextCycle();
    endtask

    // Monitor: every observed event must match the head of its queue.
    logic [NC-1:0] hs_now;
    hs_t           hs_e;
    acc_t          acc_e;
    sync_t         sync_e;
    always @(negedge clk) begin
        if (mon_en) begin
            hs_now = bus.clu_req_valid_o & bus.clu_req_ready_i;
            if (hs_now != '0) begin
                if (hs_q.size() == 0) unexpected("cluster handshake", 128'(hs_now));
                else begin
                    hs_e = hs_q.pop_front();
                    checkOutput("handshake cycle", 128'(cyc), 128'(hs_e.cyc));
                    checkOutput("handshake mask", 128'(hs_now), 128'(hs_e.mask));
                end
            end
            if (bus.req_valid_i && bus.req_ready_o) begin
                if (acc_q.size() == 0) unexpected("upstream accept", bus.req_data_i);
                else begin
                    acc_e = acc_q.pop_front();
                    checkOutput("accept cycle", 128'(cyc), 128'(acc_e.cyc));
                    checkOutput("accept payload", bus.clu_req_data_o, acc_e.data);
                    checkOutput("accept outstanding", 128'(bus.outstanding_o), 128'(acc_e.outst));
                end
            end
            if (bus.compl_sync_o != '0) begin
                if (sync_q.size() == 0) unexpected("compl_sync pulse", 128'(bus.compl_sync_o));
                else begin
                    sync_e = sync_q.pop_front();
                    checkOutput("compl_sync cycle", 128'(cyc), 128'(sync_e.cyc));
                    checkOutput("compl_sync lanes", 128'(bus.compl_sync_o), 128'(sync_e.lanes));
                end
            end
        end
    end

    function automatic logic [NC*NU-1:0] lane3Pattern(input int t);
        case (t)
            0:       return 32'h0000_0008;
            2:       return 32'h0101_0101;
            4:       return 32'h0000_0800;
            5:       return 32'h0000_0008;
            7:       return 32'h0008_0000;
            9:       return 32'h0800_0000;
            12:      return 32'h0800_0000;
            13:      return 32'h0008_0808;
            default: return 32'h0000_0000;
        endcase
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        applyStimulus(1'b0, '0, '0, '0, '0);
        checkOutput("reset outstanding", 128'(bus.outstanding_o), 128'(0));
        checkOutput("reset busy", 128'(bus.busy_o), 128'(0));
        checkOutput("reset compl_sync", 128'(bus.compl_sync_o), 128'(0));
        checkOutput("reset timeout", 128'(bus.timeout_o), 128'(0));
        checkOutput("reset clu valid", 128'(bus.clu_req_valid_o), 128'(0));
        mon_en = 1'b1;
        nextCycle();

        $display("[TB] staggered cluster ready, all enabled");
        t0 = cyc;
        hs_q.push_back('{t0, 4'b0101});
        hs_q.push_back('{t0 + 2, 4'b0010});
        hs_q.push_back('{t0 + 5, 4'b1000});
        acc_q.push_back('{t0 + 5, D1, 0});
        for (int t = 0; t < 6; t++) begin
            applyStimulus(1'b1, D1, (t == 0) ? 4'b0101 : (t == 2) ? 4'b0010 :
                          (t == 5) ? 4'b1000 : 4'b0000, '0, '0);
            if (t == 1) checkOutput("fork valid after c0/c2", 128'(bus.clu_req_valid_o), 128'(4'b1010));
            if (t == 3) checkOutput("fork valid after c1", 128'(bus.clu_req_valid_o), 128'(4'b1000));
            if (t == 4) checkOutput("req_ready while c3 pending", 128'(bus.req_ready_o), 128'(0));
            nextCycle();
        end
        applyStimulus(1'b0, '0, '0, '0, '0);
        checkOutput("outstanding after first", 128'(bus.outstanding_o), 128'(1));
        checkOutput("busy after first", 128'(bus.busy_o), 128'(1));
        nextCycle();
        retireCycle(4'hF);
        applyStimulus(1'b0, '0, '0, '0, '0);
        checkOutput("outstanding after retire", 128'(bus.outstanding_o), 128'(0));
        nextCycle();

        $display("[TB] partial mask 0101");
        en_cur = 4'b0101;
        idleCycle();
        t0 = cyc;
        hs_q.push_back('{t0, 4'b0101});
        acc_q.push_back('{t0, D2, 0});
        applyStimulus(1'b1, D2, 4'hF, '0, '0);
        checkOutput("masked fork valid", 128'(bus.clu_req_valid_o), 128'(4'b0101));
        checkOutput("masked req_ready", 128'(bus.req_ready_o), 128'(1));
        nextCycle();
        retireCycle(4'b0101);
        t0 = cyc;
        sync_q.push_back('{t0 + 1, 8'h02});
        applyStimulus(1'b0, '0, '0, 32'h0002_0202, '0);
        checkOutput("outstanding after masked retire", 128'(bus.outstanding_o), 128'(0));
        nextCycle();
        idleCycle();
        en_cur = 4'hF;
        idleCycle();

        $display("[TB] completion merge lane 3");
        t0 = cyc;
        sync_q.push_back('{t0 + 3, 8'h01});
        sync_q.push_back('{t0 + 10, 8'h08});
        sync_q.push_back('{t0 + 14, 8'h08});
        for (int t = 0; t < 16; t++) begin
            applyStimulus(1'b0, '0, '0, lane3Pattern(t), '0);
            nextCycle();
        end

        $display("[TB] credit limit with MaxOutstanding=2");
        t0 = cyc;
        hs_q.push_back('{t0, 4'hF});
        hs_q.push_back('{t0 + 1, 4'hF});
        hs_q.push_back('{t0 + 5, 4'hF});
        acc_q.push_back('{t0, D3, 0});
        acc_q.push_back('{t0 + 1, D4, 1});
        acc_q.push_back('{t0 + 5, D5, 1});
        for (int t = 0; t < 6; t++) begin
            applyStimulus(1'b1, (t == 0) ? D3 : (t == 1) ? D4 : D5, 4'hF, '0,
                          (t == 4) ? 4'hF : 4'h0);
            if (t == 3) begin
                checkOutput("stalled req_ready", 128'(bus.req_ready_o), 128'(0));
                checkOutput("stalled fork valid", 128'(bus.clu_req_valid_o), 128'(0));
                checkOutput("stalled outstanding", 128'(bus.outstanding_o), 128'(2));
            end
            nextCycle();
        end
        applyStimulus(1'b0, '0, '0, '0, '0);
        checkOutput("outstanding after refill", 128'(bus.outstanding_o), 128'(2));
        nextCycle();
        retireCycle(4'hF);

        $display("[TB] reset mid-fork");
        t0 = cyc;
        hs_q.push_back('{t0, 4'b0011});
        hs_q.push_back('{t0 + 3, 4'hF});
        acc_q.push_back('{t0 + 3, D6, 0});
        applyStimulus(1'b1, D6, 4'b0011, 32'h0000_0020, '0);
        checkOutput("pre-reset outstanding", 128'(bus.outstanding_o), 128'(1));
        nextCycle();
        rst_n = 1'b0;
        applyStimulus(1'b1, D6, 4'b0000, '0, '0);
        checkOutput("fork valid with sent 0011", 128'(bus.clu_req_valid_o), 128'(4'b1100));
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, D6, 4'b0000, '0, '0);
        checkOutput("post-reset outstanding", 128'(bus.outstanding_o), 128'(0));
        checkOutput("post-reset fork valid", 128'(bus.clu_req_valid_o), 128'(4'hF));
        checkOutput("post-reset busy", 128'(bus.busy_o), 128'(0));
        nextCycle();
        applyStimulus(1'b1, D6, 4'hF, 32'h2020_2000, '0);
        nextCycle();
        idleCycle();
        applyStimulus(1'b0, '0, '0, '0, '0);
        checkOutput("outstanding after resend", 128'(bus.outstanding_o), 128'(1));
        nextCycle();
        retireCycle(4'hF);

        $display("[TB] slow cluster 1 watchdog");
        t0 = cyc;
        hs_q.push_back('{t0, 4'b1101});
        hs_q.push_back('{t0 + 20, 4'b0010});
        acc_q.push_back('{t0 + 20, D7, 0});
        for (int t = 0; t < 21; t++) begin
            applyStimulus(1'b1, D7, (t == 0) ? 4'b1101 : (t == 20) ? 4'b0010 : 4'b0000, '0, '0);
            if (t == 16) checkOutput("timeout before limit", 128'(bus.timeout_o), 128'(0));
            if (t == 17) checkOutput("timeout at limit", 128'(bus.timeout_o), 128'(TimeoutExp));
            nextCycle();
        end
        idleCycle();
        applyStimulus(1'b0, '0, '0, '0, '0);
        checkOutput("timeout sticky", 128'(bus.timeout_o), 128'(TimeoutExp));
        checkOutput("outstanding after slow", 128'(bus.outstanding_o), 128'(1));
        nextCycle();
        retireCycle(4'hF);
        applyStimulus(1'b0, '0, '0, '0, '0);
        checkOutput("final outstanding", 128'(bus.outstanding_o), 128'(0));
        checkOutput("final busy", 128'(bus.busy_o), 128'(0));
        nextCycle();
        repeat (3) idleCycle();

        checkOutput("handshake queue drained", 128'(hs_q.size()), 128'(0));
        checkOutput("accept queue drained", 128'(acc_q.size()), 128'(0));
        checkOutput("sync queue drained", 128'(sync_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
